hv_seg_assembler: RTL and testbench
===================================

HV_SEG_ASSEMBLER -- requirements
Module: hv_seg_assembler

Interface
REQ-001 SHALL have parameter HV_DIM, default 4096, full hypervector width in bits.
REQ-002 SHALL have parameter DIMS_PER_CC, default 1024, segment width in bits, transferred once per accepted cycle.
REQ-003 SHALL derive NUM_SEGS = HV_DIM/DIMS_PER_CC (default 4) and SEG_IDX_W = clog2(NUM_SEGS) (default 2).
REQ-004 SHALL have ports:
  clk  input  1  single clock; all state changes on rising edge.
  nrst  input  1  reset, asynchronous, active-low.
  flush  input  1  synchronous discard of any partially assembled HV.
  seg_valid  input  1  seg_data holds a valid segment.
  seg_ready  output  1  block accepts a segment this cycle.
  seg_data  input  DIMS_PER_CC  incoming segment.
  seg_idx  output  SEG_IDX_W  index of the slot the next accepted segment fills.
  hv_valid  output  1  hv_out holds a complete HV.
  hv_ready  input  1  consumer takes hv_out this cycle.
  hv_out  output  HV_DIM  assembled hypervector, registered.

Function
REQ-005 SHALL implement two states: COLLECT (gathering segments) and FULL (complete HV held).
REQ-006 SHALL define a segment transfer as seg_valid && seg_ready at a rising clk edge, and an HV transfer as hv_valid && hv_ready.
REQ-007 SHALL write the segment accepted at index k into hv_out[k*DIMS_PER_CC +: DIMS_PER_CC]; segment 0 = bits [DIMS_PER_CC-1:0]; other slices unchanged.
REQ-008 SHALL increment seg_idx by 1 on each segment transfer, wrapping NUM_SEGS-1 -> 0.
REQ-009 SHALL move COLLECT -> FULL on the segment transfer with seg_idx == NUM_SEGS-1; hv_valid high the following cycle (latency 1 cycle after last segment).
REQ-010 SHALL drive seg_ready = 1 in COLLECT, and seg_ready = hv_ready in FULL.
REQ-011 SHALL hold hv_valid high and hv_out stable in FULL until an HV transfer occurs, regardless of seg_valid.
REQ-012 SHALL, on HV transfer without simultaneous segment transfer, go FULL -> COLLECT with hv_valid low next cycle.
REQ-013 SHALL, on HV transfer with simultaneous segment transfer, go to COLLECT, store the new segment in slot 0 and set seg_idx = 1 (sustained throughput 1 HV per NUM_SEGS cycles).
REQ-014 SHALL, on flush, next cycle set state COLLECT, seg_idx 0, hv_valid 0; no segment accepted that cycle (flush overrides seg_valid); hv_out contents not cleared.
REQ-015 SHALL ignore seg_data when no segment transfer occurs; seg_valid low mid-HV leaves seg_idx and stored slices unchanged.
REQ-016 SHALL make seg_ready and seg_idx depend only on registered state and hv_ready (no combinational seg_valid->seg_ready path).

Reset
REQ-017 SHALL, while nrst is low, force state COLLECT, seg_idx 0, hv_valid 0, hv_out all zeros, independent of clk.
REQ-018 SHALL drive seg_ready = 1 during and immediately after reset.
REQ-019 SHALL discard any partial or held HV on reset asserted mid-operation; first segment after deassertion goes to slot 0.

Structure
REQ-020 SHALL take HV_DIM, DIMS_PER_CC, NUM_SEGS, SEG_IDX_W and the COLLECT/FULL state enum from the shared package hdc_pkg.
REQ-021 SHALL be a single module with no sub-modules; seg_idx numbering SHALL match the query_ctr segment numbering used by the associative-memory segment selector.

Verification
REQ-022 Reset: nrst low then high, no stimulus -> hv_valid 0, seg_idx 0, seg_ready 1, hv_out 0.
REQ-023 Back-to-back fill: segments 1024'hA, 'hB, 'hC, 'hD on 4 consecutive cycles, hv_ready 0 -> next cycle hv_valid 1, hv_out = {D,C,B,A}, seg_ready 0; holds 10 cycles unchanged.
REQ-024 Overlap: in FULL, hv_ready 1 with seg_valid 1 seg_data 'hE -> next cycle hv_valid 0, seg_idx 1, hv_out[1023:0] = 'hE.
REQ-025 Gaps: 4 segments with seg_valid low 3 cycles between each -> same {D,C,B,A} result, seg_idx steps only on transfers.
REQ-026 Flush: accept 2 segments, assert flush with seg_valid 1 -> seg_idx 0 next cycle, segment not stored; next 4 segments produce a clean HV.
REQ-027 Async reset mid-HV: nrst low between clk edges after 3 segments -> outputs reset immediately, before next clk edge.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared HDC datapath constants and the segment-assembler state type.
// Widths here are the system defaults; instantiations may override them.
package hdc_pkg;

    localparam int unsigned HV_DIM      = 4096;
    localparam int unsigned DIMS_PER_CC = 1024;
    localparam int unsigned NUM_SEGS    = HV_DIM / DIMS_PER_CC;
    localparam int unsigned SEG_IDX_W   = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;

    typedef enum logic {
        StCollect,
        StFull
    } asm_state_e;

endpackage

// File: rtl/hv_seg_assembler.sv
// Gathers NUM_SEGS consecutive segments into one registered hypervector and holds it
// until the consumer takes it; slot numbering matches the AM segment selector's query_ctr.
module hv_seg_assembler
    import hdc_pkg::asm_state_e, hdc_pkg::StCollect, hdc_pkg::StFull;
#(
    parameter int unsigned HV_DIM      = hdc_pkg::HV_DIM,
    parameter int unsigned DIMS_PER_CC = hdc_pkg::DIMS_PER_CC,
    localparam int unsigned NUM_SEGS   = HV_DIM / DIMS_PER_CC,
    localparam int unsigned SEG_IDX_W  = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   flush,
    input  logic                   seg_valid,
    output logic                   seg_ready,
    input  logic [DIMS_PER_CC-1:0] seg_data,
    output logic [SEG_IDX_W-1:0]   seg_idx,
    output logic                   hv_valid,
    input  logic                   hv_ready,
    output logic [HV_DIM-1:0]      hv_out
);

    localparam logic [SEG_IDX_W-1:0] LastIdx = SEG_IDX_W'(NUM_SEGS - 1);

    asm_state_e           state_q, state_d;
    logic [SEG_IDX_W-1:0] seg_idx_q, seg_idx_d;
    logic [HV_DIM-1:0]    hv_q, hv_d;

    logic seg_fire;
    logic hv_fire;

    // In FULL a new segment is only taken when the held HV leaves in the same cycle.
    assign seg_ready = (state_q == StCollect) ? 1'b1 : hv_ready;
    assign hv_valid  = (state_q == StFull);
    assign seg_idx   = seg_idx_q;
    assign hv_out    = hv_q;

    assign seg_fire = seg_valid && seg_ready && !flush;
    assign hv_fire  = hv_valid && hv_ready;

    always_comb begin
        state_d   = state_q;
        seg_idx_d = seg_idx_q;
        hv_d      = hv_q;
        if (flush) begin
            state_d   = StCollect;
            seg_idx_d = '0;
        end else begin
            if (hv_fire) begin
                state_d = StCollect;
            end
            // seg_idx_q is already 0 in FULL, so an overlapped segment lands in slot 0.
            if (seg_fire) begin
                hv_d[int'(seg_idx_q) * DIMS_PER_CC +: DIMS_PER_CC] = seg_data;
                if (seg_idx_q == LastIdx) begin
                    seg_idx_d = '0;
                    state_d   = StFull;
                end else begin
                    seg_idx_d = seg_idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= StCollect;
            seg_idx_q <= '0;
            hv_q      <= '0;
        end else begin
            state_q   <= state_d;
            seg_idx_q <= seg_idx_d;
            hv_q      <= hv_d;
        end
    end

endmodule

// File: tb/tb_hv_seg_assembler.sv
// Directed self-checking bench for hv_seg_assembler at default widths (4096 / 1024).
module tb_hv_seg_assembler;

    localparam int unsigned HvDim = 4096;
    localparam int unsigned Dpc   = 1024;

    logic            clk;
    logic            nrst;
    logic            flush;
    logic            seg_valid;
    logic            seg_ready;
    logic [Dpc-1:0]  seg_data;
    logic [1:0]      seg_idx;
    logic            hv_valid;
    logic            hv_ready;
    logic [HvDim-1:0] hv_out;

    int checks = 0;
    int errors = 0;

    hv_seg_assembler dut (
        .clk       (clk),
        .nrst      (nrst),
        .flush     (flush),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .seg_data  (seg_data),
        .seg_idx   (seg_idx),
        .hv_valid  (hv_valid),
        .hv_ready  (hv_ready),
        .hv_out    (hv_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_hv(input string tag, input logic [HvDim-1:0] exp);
        checks++;
        assert (hv_out === exp) else begin
            errors++;
            $error("FAIL %s observed slots %0h/%0h/%0h/%0h expected %0h/%0h/%0h/%0h", tag,
                   hv_out[3*Dpc +: 64], hv_out[2*Dpc +: 64], hv_out[Dpc +: 64], hv_out[63:0],
                   exp[3*Dpc +: 64], exp[2*Dpc +: 64], exp[Dpc +: 64], exp[63:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [HvDim-1:0] exp_hv;

    initial begin
        nrst      = 1'b0;
        flush     = 1'b0;
        seg_valid = 1'b0;
        seg_data  = '0;
        hv_ready  = 1'b0;

        // Reset
        #12;
        chk("rst_ready_during", 64'(seg_ready), 64'd1);
        nrst = 1'b1;
        tick();
        chk("rst_hv_valid", 64'(hv_valid), 64'd0);
        chk("rst_seg_idx", 64'(seg_idx), 64'd0);
        chk("rst_seg_ready", 64'(seg_ready), 64'd1);
        chk_hv("rst_hv_out", '0);

        // Back-to-back fill, consumer stalled
        seg_valid = 1'b1;
        seg_data  = 1024'hA;
        tick();
        chk("b2b_idx1", 64'(seg_idx), 64'd1);
        chk("b2b_not_full1", 64'(hv_valid), 64'd0);
        seg_data = 1024'hB;
        tick();
        chk("b2b_idx2", 64'(seg_idx), 64'd2);
        seg_data = 1024'hC;
        tick();
        chk("b2b_idx3", 64'(seg_idx), 64'd3);
        chk("b2b_not_full3", 64'(hv_valid), 64'd0);
        seg_data = 1024'hD;
        tick();
        exp_hv = {1024'hD, 1024'hC, 1024'hB, 1024'hA};
        chk("b2b_hv_valid", 64'(hv_valid), 64'd1);
        chk("b2b_seg_ready", 64'(seg_ready), 64'd0);
        chk("b2b_idx_wrap", 64'(seg_idx), 64'd0);
        chk_hv("b2b_hv_out", exp_hv);

        // Hold while full, even with seg_valid asserted
        seg_data = 1024'h55;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_hv_valid", 64'(hv_valid), 64'd1);
            chk_hv("hold_hv_out", exp_hv);
        end

        // Overlap: HV leaves and a new segment enters slot 0 on the same edge
        hv_ready = 1'b1;
        seg_data = 1024'hE;
        #1;
        chk("ovl_seg_ready_follows", 64'(seg_ready), 64'd1);
        tick();
        seg_valid = 1'b0;
        hv_ready  = 1'b0;
        chk("ovl_hv_valid", 64'(hv_valid), 64'd0);
        chk("ovl_seg_idx", 64'(seg_idx), 64'd1);
        chk_hv("ovl_hv_out", {1024'hD, 1024'hC, 1024'hB, 1024'hE});

        // Flush the partial HV before the gap test
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl0_seg_idx", 64'(seg_idx), 64'd0);

        // Gaps: three idle cycles with junk data between transfers
        for (int k = 0; k < 4; k++) begin
            seg_valid = 1'b1;
            seg_data  = Dpc'(10 + k);
            tick();
            seg_valid = 1'b0;
            seg_data  = 1024'hFF;
            for (int g = 0; g < 3; g++) begin
                tick();
                chk("gap_seg_idx", 64'(seg_idx), 64'((k + 1) % 4));
            end
        end
        chk("gap_hv_valid", 64'(hv_valid), 64'd1);
        chk_hv("gap_hv_out", exp_hv);

        // Plain HV transfer without a new segment; contents remain
        hv_ready = 1'b1;
        tick();
        hv_ready = 1'b0;
        chk("drain_hv_valid", 64'(hv_valid), 64'd0);
        chk("drain_seg_idx", 64'(seg_idx), 64'd0);
        chk("drain_seg_ready", 64'(seg_ready), 64'd1);
        chk_hv("drain_hv_kept", exp_hv);

        // Flush after two segments overrides a valid segment
        seg_valid = 1'b1;
        seg_data  = 1024'h1;
        tick();
        seg_data = 1024'h2;
        tick();
        chk("fl_pre_idx", 64'(seg_idx), 64'd2);
        seg_data = 1024'h99;
        flush    = 1'b1;
        tick();
        flush     = 1'b0;
        seg_valid = 1'b0;
        chk("fl_seg_idx", 64'(seg_idx), 64'd0);
        chk("fl_hv_valid", 64'(hv_valid), 64'd0);
        chk_hv("fl_not_stored", {1024'hD, 1024'hC, 1024'h2, 1024'h1});
        seg_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            seg_data = Dpc'(5 + k);
            tick();
        end
        seg_valid = 1'b0;
        chk("fl_clean_valid", 64'(hv_valid), 64'd1);
        chk_hv("fl_clean_hv", {1024'h8, 1024'h7, 1024'h6, 1024'h5});

        // Async reset mid-HV, checked before the next clock edge
        hv_ready = 1'b1;
        tick();
        hv_ready  = 1'b0;
        seg_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            seg_data = Dpc'(9 + k);
            tick();
        end
        seg_valid = 1'b0;
        chk("ar_pre_idx", 64'(seg_idx), 64'd3);
        #2;
        nrst = 1'b0;
        #1;
        chk("ar_seg_idx", 64'(seg_idx), 64'd0);
        chk("ar_hv_valid", 64'(hv_valid), 64'd0);
        chk("ar_seg_ready", 64'(seg_ready), 64'd1);
        chk_hv("ar_hv_out", '0);
        #3;
        nrst = 1'b1;
        tick();
        seg_valid = 1'b1;
        seg_data  = 1024'h3;
        tick();
        seg_valid = 1'b0;
        chk("ar_first_idx", 64'(seg_idx), 64'd1);
        chk_hv("ar_first_slot0", {3072'h0, 1024'h3});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
